// File: rtl/asrm_pkg.sv
// Shared constants and FSM encoding for the asrm DMA engine.
package asrm_pkg;

    localparam int unsigned REG_SRC  = 0;
    localparam int unsigned REG_DST  = 1;
    localparam int unsigned REG_LEN  = 2;
    localparam int unsigned REG_CTRL = 3;
    localparam int unsigned NUM_REGS = 4;

    localparam int unsigned CTRL_BUSY = 0;
    localparam int unsigned CTRL_DONE = 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRead,
        StCapture,
        StWrite
    } state_e;

endpackage

// File: rtl/asrm_dma_if.sv
// System-bus bundle for asrm_dma: CPU responder port plus arbitrated initiator port.
interface asrm_dma_if #(
    parameter int unsigned WORDSIZE       = 8,
    parameter int unsigned BASE_ADDR_SIZE = 7
) ();

    logic                      enable;
    logic [BASE_ADDR_SIZE-1:0] addr;
    logic                      write_en;
    logic [WORDSIZE-1:0]       data_in;
    logic [WORDSIZE-1:0]       data_out;

    logic                      m_req;
    logic                      m_grant;
    logic [WORDSIZE-1:0]       m_addr;
    logic                      m_write_en;
    logic [WORDSIZE-1:0]       m_data_out;
    logic [WORDSIZE-1:0]       m_data_in;

    // Device side (the DMA engine).
    modport slave (
        input  enable, addr, write_en, data_in, m_grant, m_data_in,
        output data_out, m_req, m_addr, m_write_en, m_data_out
    );

    // System side (CPU, address decoder, arbiter and memories).
    modport master (
        output enable, addr, write_en, data_in, m_grant, m_data_in,
        input  data_out, m_req, m_addr, m_write_en, m_data_out
    );

endinterface

// File: rtl/asrm_dma_regs.sv
// Responder-port decode, SRC/DST/LEN/DONE register file and OR-bus read mux.
module asrm_dma_regs
    import asrm_pkg::*;
#(
    parameter int unsigned                WORDSIZE       = 8,
    parameter int unsigned                BASE_ADDR_SIZE = 7,
    parameter logic [BASE_ADDR_SIZE-1:0] BASE_ADDR      = 7'h10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_i,
    input  logic [BASE_ADDR_SIZE-1:0] addr_i,
    input  logic                      write_en_i,
    input  logic [WORDSIZE-1:0]       data_in_i,
    output logic [WORDSIZE-1:0]       data_out_o,
    input  logic                      busy_i,
    input  logic                      step_i,
    input  logic                      set_done_i,
    output logic [WORDSIZE-1:0]       src_o,
    output logic [WORDSIZE-1:0]       dst_o,
    output logic [WORDSIZE-1:0]       len_o,
    output logic                      start_o,
    output logic                      done_o
);

    logic [WORDSIZE-1:0]       src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic                      done_q, done_d, start_q, start_d;
    logic [BASE_ADDR_SIZE-1:0] off;
    logic [1:0]                sel;
    logic                      hit, wr, ctrl_wr;

    assign off     = addr_i - BASE_ADDR;
    assign hit     = enable_i && (addr_i >= BASE_ADDR) && (off < BASE_ADDR_SIZE'(NUM_REGS));
    assign sel     = off[1:0];
    assign wr      = hit && write_en_i;
    assign ctrl_wr = wr && (sel == 2'(REG_CTRL));

    always_comb begin
        data_out_o = '0;
        if (hit) begin
            unique case (sel)
                2'(REG_SRC): data_out_o = src_q;
                2'(REG_DST): data_out_o = dst_q;
                2'(REG_LEN): data_out_o = len_q;
                default: begin
                    data_out_o[CTRL_BUSY] = busy_i;
                    data_out_o[CTRL_DONE] = done_q;
                end
            endcase
        end
    end

    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        start_d = ctrl_wr && !busy_i && data_in_i[CTRL_BUSY];
        if (wr && !busy_i) begin
            if (sel == 2'(REG_SRC)) src_d = data_in_i;
            if (sel == 2'(REG_DST)) dst_d = data_in_i;
            if (sel == 2'(REG_LEN)) len_d = data_in_i;
        end
        if (step_i) begin
            src_d = src_q + WORDSIZE'(1);
            dst_d = dst_q + WORDSIZE'(1);
            len_d = len_q - WORDSIZE'(1);
        end
        done_d = done_q;
        if (ctrl_wr && (data_in_i[CTRL_DONE] || start_d)) done_d = 1'b0;
        // Completion outranks a same-cycle software clear.
        if (set_done_i) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign len_o   = len_q;
    assign start_o = start_q;
    assign done_o  = done_q;

endmodule

// File: rtl/asrm_dma.sv
// Single-channel memory-to-memory copy engine: register slice plus initiator FSM/datapath.
module asrm_dma
    import asrm_pkg::*;
#(
    parameter int unsigned                WORDSIZE       = 8,
    parameter int unsigned                BASE_ADDR_SIZE = 7,
    parameter logic [BASE_ADDR_SIZE-1:0] BASE_ADDR      = 7'h10
) (
    input  logic       clk,
    input  logic       reset,
    asrm_dma_if.slave  bus,
    output logic       done
);

    state_e              state_q;
    logic                m_req_q, m_we_q;
    logic [WORDSIZE-1:0] m_addr_q, buf_q;
    logic [WORDSIZE-1:0] src, dst, len;
    logic                start, busy, step, set_done;

    assign busy     = (state_q != StIdle);
    assign step     = (state_q == StWrite);
    assign set_done = ((state_q == StIdle) && start && (len == '0)) ||
                      ((state_q == StWrite) && (len == WORDSIZE'(1)));

    asrm_dma_regs #(
        .WORDSIZE      (WORDSIZE),
        .BASE_ADDR_SIZE(BASE_ADDR_SIZE),
        .BASE_ADDR     (BASE_ADDR)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (bus.enable),
        .addr_i    (bus.addr),
        .write_en_i(bus.write_en),
        .data_in_i (bus.data_in),
        .data_out_o(bus.data_out),
        .busy_i    (busy),
        .step_i    (step),
        .set_done_i(set_done),
        .src_o     (src),
        .dst_o     (dst),
        .len_o     (len),
        .start_o   (start),
        .done_o    (done)
    );

    // Bus outputs are registered and forced to zero outside READ/CAPTURE/WRITE for the OR bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            m_req_q  <= 1'b0;
            m_addr_q <= '0;
            m_we_q   <= 1'b0;
            buf_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (len != '0)) begin
                        state_q <= StReq;
                        m_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus.m_grant) begin
                        state_q  <= StRead;
                        m_addr_q <= src;
                    end
                end
                StRead: state_q <= StCapture;
                StCapture: begin
                    state_q  <= StWrite;
                    buf_q    <= bus.m_data_in;
                    m_addr_q <= dst;
                    m_we_q   <= 1'b1;
                end
                StWrite: begin
                    m_we_q <= 1'b0;
                    buf_q  <= '0;
                    if (len == WORDSIZE'(1)) begin
                        state_q  <= StIdle;
                        m_req_q  <= 1'b0;
                        m_addr_q <= '0;
                    end else begin
                        // SRC advances on this same edge, so the next read uses src + 1.
                        state_q  <= StRead;
                        m_addr_q <= src + WORDSIZE'(1);
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    m_req_q  <= 1'b0;
                    m_addr_q <= '0;
                    m_we_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_req      = m_req_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_write_en = m_we_q;
    assign bus.m_data_out = buf_q;

endmodule

// File: tb/tb_asrm_dma.sv
// Scoreboard bench for asrm_dma: expected bus writes and register reads are queued by the
// stimulus and checked by a negedge monitor.
module tb_asrm_dma;

    localparam int unsigned WS   = 8;
    localparam int unsigned AS   = 7;
    localparam logic [6:0]  BASE = 7'h10;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rd_mon = 1'b0;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    string      rd_name_q[$];

    asrm_dma_if #(.WORDSIZE(WS), .BASE_ADDR_SIZE(AS)) bus ();

    asrm_dma #(
        .WORDSIZE      (WS),
        .BASE_ADDR_SIZE(AS),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [7:0] a);
        logic [7:0] t;
        t = a * 8'd29;
        return t ^ 8'h5A;
    endfunction

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) bus.m_data_in <= rom_byte(bus.m_addr);

    always @(negedge clk) begin
        if (bus.m_write_en === 1'b1) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_err++;
                $display("FAIL bus_write: got unexpected write addr=%0h data=%0h",
                         bus.m_addr, bus.m_data_out);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                if ({bus.m_addr, bus.m_data_out} !== e) begin
                    n_err++;
                    $display("FAIL bus_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             bus.m_addr, bus.m_data_out, e.addr, e.data);
                end
            end
        end
        if (rd_mon && bus.enable && !bus.write_en) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL reg_read: got unexpected read data=%0h", bus.data_out);
            end else begin
                logic [7:0] e;
                string      nm;
                e  = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                if (bus.data_out !== e) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h", nm, bus.data_out, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cpu_write(input int off, input logic [7:0] d);
        bus.enable   = 1'b1;
        bus.addr     = 7'(int'(BASE) + off);
        bus.write_en = 1'b1;
        bus.data_in  = d;
        @(posedge clk);
        #1;
        bus.enable   = 1'b0;
        bus.write_en = 1'b0;
        bus.addr     = '0;
        bus.data_in  = '0;
    endtask

    task automatic cpu_read(input logic [6:0] a, input logic [7:0] exp, input string nm);
        rd_q.push_back(exp);
        rd_name_q.push_back(nm);
        bus.enable   = 1'b1;
        bus.addr     = a;
        bus.write_en = 1'b0;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        bus.addr   = '0;
    endtask

    task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = d + 8'(i);
            e.data = rom_byte(s + 8'(i));
            wr_q.push_back(e);
        end
    endtask

    task automatic setup(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        cpu_write(0, s);
        cpu_write(1, d);
        cpu_write(2, n);
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bit bad;
        bus.enable   = 1'b0;
        bus.addr     = '0;
        bus.write_en = 1'b0;
        bus.data_in  = '0;
        bus.m_grant  = 1'b0;

        // Reset held with random bus activity.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("reset_outputs",
                  {bus.data_out, bus.m_req, bus.m_addr, bus.m_write_en, bus.m_data_out, done}, 0);
            bus.enable   = 1'($urandom);
            bus.addr     = 7'(BASE + 7'($urandom_range(0, 5)));
            bus.write_en = 1'($urandom);
            bus.data_in  = 8'($urandom);
            bus.m_grant  = 1'($urandom);
        end
        bus.enable   = 1'b0;
        bus.write_en = 1'b0;
        bus.addr     = '0;
        bus.m_grant  = 1'b1;
        reset        = 1'b1;
        rd_mon       = 1'b1;
        @(posedge clk);
        #1;
        cpu_read(BASE + 7'd3, 8'h00, "reset_ctrl");
        cpu_read(BASE, 8'h00, "reset_src");

        // Basic copy, grant tied high: 2 + 3*3 cycles.
        setup(8'h00, 8'h90, 8'd3);
        push_copy(8'h00, 8'h90, 3);
        cpu_write(3, 8'h01);
        wait_done(100, cyc);
        check("copy3_cycles", cyc, 11);
        check("copy3_writes_left", wr_q.size(), 0);
        check("copy3_req_low", bus.m_req, 0);
        cpu_read(BASE + 7'd3, 8'h02, "copy3_ctrl");
        cpu_read(BASE + 7'd4, 8'h00, "unmapped_above");
        cpu_read(BASE - 7'd1, 8'h00, "unmapped_below");
        cpu_write(3, 8'h02);
        cpu_read(BASE + 7'd3, 8'h00, "done_cleared");

        // Grant held low: request but no address activity.
        bus.m_grant = 1'b0;
        setup(8'h10, 8'hA0, 8'd2);
        push_copy(8'h10, 8'hA0, 2);
        cpu_write(3, 8'h01);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_req !== 1'b1 || bus.m_addr !== 8'h00 || bus.m_write_en !== 1'b0) bad = 1'b1;
        end
        check("grant_wait_idle_bus", bad, 0);
        cpu_read(BASE + 7'd3, 8'h01, "grant_wait_busy");
        bus.m_grant = 1'b1;
        wait_done(100, cyc);
        check("grant_done", done, 1);
        check("grant_writes_left", wr_q.size(), 0);

        // Source address wraps.
        setup(8'hFE, 8'h40, 8'd4);
        push_copy(8'hFE, 8'h40, 4);
        cpu_write(3, 8'h01);
        wait_done(100, cyc);
        check("wrap_cycles", cyc, 14);
        cpu_read(BASE, 8'h02, "wrap_src");
        cpu_read(BASE + 7'd1, 8'h44, "wrap_dst");
        cpu_read(BASE + 7'd2, 8'h00, "wrap_len");

        // Zero length: DONE next edge, never a request.
        cpu_write(2, 8'h00);
        cpu_write(3, 8'h01);
        check("len0_done_cleared", done, 0);
        bad = bus.m_req;
        @(posedge clk);
        #1;
        check("len0_done_set", done, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_req !== 1'b0) bad = 1'b1;
        end
        check("len0_no_req", bad, 0);
        cpu_read(BASE + 7'd3, 8'h02, "len0_ctrl");

        // Register writes and restart while busy are ignored.
        setup(8'h20, 8'h60, 8'd3);
        push_copy(8'h20, 8'h60, 3);
        cpu_write(3, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        cpu_write(0, 8'h77);
        cpu_write(3, 8'h01);
        cpu_write(2, 8'h09);
        wait_done(100, cyc);
        check("busy_writes_done", done, 1);
        cpu_read(BASE, 8'h23, "busy_src");
        cpu_read(BASE + 7'd1, 8'h63, "busy_dst");
        cpu_read(BASE + 7'd2, 8'h00, "busy_len");
        repeat (3) @(posedge clk);
        #1;
        check("busy_no_restart", bus.m_req, 0);

        // Reset during the second WRITE aborts.
        setup(8'h30, 8'h70, 8'd3);
        push_copy(8'h30, 8'h70, 2);
        cpu_write(3, 8'h01);
        repeat (7) @(posedge clk);
        #1;
        check("abort_in_write", bus.m_write_en, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_bus_zero", {bus.m_req, bus.m_write_en, bus.m_addr, bus.m_data_out}, 0);
        check("abort_done", done, 0);
        reset = 1'b1;
        cpu_read(BASE, 8'h00, "abort_src");
        cpu_read(BASE + 7'd1, 8'h00, "abort_dst");
        cpu_read(BASE + 7'd2, 8'h00, "abort_len");
        cpu_read(BASE + 7'd3, 8'h00, "abort_ctrl");
        repeat (4) @(posedge clk);
        #1;
        check("abort_stays_idle", bus.m_req, 0);

        check("final_writes_left", wr_q.size(), 0);
        check("final_reads_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
